// File: rtl/conv_result_streamer_if.sv
// Output stream bus of the conv result streamer: packed words carried on a
// valid/ready handshake, with a last-word marker that closes each frame.
interface conv_result_streamer_if #(
   parameter int DATA_W = 4,
   parameter int PACK   = 8
);
   logic [PACK*DATA_W-1:0] m_data;
   logic                   m_valid;
   logic                   m_ready;
   logic                   m_last;

   modport master (output m_data, output m_valid, output m_last, input m_ready);
   modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/conv_result_streamer.sv
// Drains the accelerator output buffer once it reports done: walks the read
// address from 0 to NUM_ELEMS-1 (one-cycle read latency), packs PACK elements
// per word (lowest address in the low bits) and streams the words out.
// A pack register feeds an output register, so the stream runs at one element
// per cycle without bubbles; an address is only issued when the returning
// element is guaranteed a pack slot. Requires PACK >= 2.
module conv_result_streamer #(
   parameter int NUM_ELEMS = 7840,
   parameter int DATA_W    = 4,
   parameter int PACK      = 8,
   parameter int ADDR_W    = 32
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   start,
   input  logic                   acc_done,
   output logic [ADDR_W-1:0]      acc_read_addr,
   input  logic [DATA_W-1:0]      acc_read_data,
   conv_result_streamer_if.master m_if,
   output logic                   busy,
   output logic                   stream_done
);
   localparam int CNT_W  = $clog2(NUM_ELEMS + 1);
   localparam int FILL_W = $clog2(PACK + 1);
   localparam int SLOT_W = $clog2(PACK);
   localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_ELEMS - 1);
   localparam logic [FILL_W-1:0] FULL_CNT = FILL_W'(PACK);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_DONE = 3'd1,
      FETCH     = 3'd2,
      DRAIN     = 3'd3,
      FIN       = 3'd4
   } state_t;

   state_t                         state_r, state_s;
   logic [ADDR_W-1:0]              addr_r, addr_s;
   logic [CNT_W-1:0]               issue_cnt_r, issue_cnt_s;
   logic [CNT_W-1:0]               cap_cnt_r, cap_cnt_s;
   logic                           rd_pend_r, issue_s;
   logic [PACK-1:0][DATA_W-1:0]    pack_r, pack_s;
   logic [FILL_W-1:0]              fill_r, fill_s;
   logic                           pack_done_r, pack_done_s;
   logic                           pack_last_r, pack_last_s;
   logic [PACK*DATA_W-1:0]         out_data_r, out_data_s;
   logic                           out_valid_r, out_valid_s;
   logic                           out_last_r, out_last_s;
   logic                           busy_r, busy_s;
   logic                           stream_done_r, stream_done_s;
   logic                           hs_s, move_s;

   assign acc_read_addr = addr_r;
   assign m_if.m_data   = out_data_r;
   assign m_if.m_valid  = out_valid_r;
   assign m_if.m_last   = out_last_r;
   assign busy          = busy_r;
   assign stream_done   = stream_done_r;

   // Next-state, packing, output-register and address-issue decisions.
   always_comb begin
      hs_s          = out_valid_r & m_if.m_ready;
      move_s        = pack_done_r & (~out_valid_r | hs_s);
      state_s       = state_r;
      addr_s        = addr_r;
      issue_cnt_s   = issue_cnt_r;
      cap_cnt_s     = cap_cnt_r;
      issue_s       = 1'b0;
      busy_s        = busy_r;
      stream_done_s = 1'b0;
      pack_done_s   = pack_done_r & ~move_s;
      pack_last_s   = pack_last_r & ~move_s;
      out_valid_s   = move_s | (out_valid_r & ~hs_s);

      // a moving word leaves a cleared pack behind, which zero-fills partial words
      if (move_s) begin
         pack_s     = '0;
         fill_s     = '0;
         out_data_s = pack_r;
         out_last_s = pack_last_r;
      end else begin
         pack_s     = pack_r;
         fill_s     = fill_r;
         out_data_s = out_data_r;
         out_last_s = out_last_r;
      end

      // element returning for the address issued last cycle
      if (rd_pend_r) begin
         pack_s[fill_s[SLOT_W-1:0]] = acc_read_data;
         fill_s    = fill_s + FILL_W'(1);
         cap_cnt_s = cap_cnt_r + CNT_W'(1);
         if ((fill_s == FULL_CNT) || (cap_cnt_r == LAST_IDX)) begin
            pack_done_s = 1'b1;
         end else begin
            pack_done_s = 1'b0;
         end
         pack_last_s = (cap_cnt_r == LAST_IDX);
      end else begin
         cap_cnt_s = cap_cnt_r;
      end

      case (state_r)
         IDLE: begin
            if (start) begin
               busy_s      = 1'b1;
               issue_cnt_s = '0;
               cap_cnt_s   = '0;
               addr_s      = '0;
               state_s     = acc_done ? FETCH : WAIT_DONE;
            end else begin
               state_s = IDLE;
            end
         end
         WAIT_DONE: begin
            if (acc_done) begin
               state_s = FETCH;
            end else begin
               state_s = WAIT_DONE;
            end
         end
         FETCH: begin
            // issue only if next cycle's element has a slot to land in
            if (~pack_done_s | ~out_valid_s) begin
               issue_s     = 1'b1;
               issue_cnt_s = issue_cnt_r + CNT_W'(1);
               if (issue_cnt_r == LAST_IDX) begin
                  state_s = DRAIN;
               end else begin
                  addr_s = addr_r + ADDR_W'(1);
               end
            end else begin
               issue_s = 1'b0;
            end
         end
         DRAIN: begin
            if (hs_s & out_last_r) begin
               state_s       = FIN;
               busy_s        = 1'b0;
               stream_done_s = 1'b1;
            end else begin
               state_s = DRAIN;
            end
         end
         FIN: begin
            state_s = IDLE;
            addr_s  = '0;
         end
         default: begin
            state_s = IDLE;
            busy_s  = 1'b0;
            addr_s  = '0;
         end
      endcase
   end

   // State, counters, pack/output registers and registered outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r       <= IDLE;
         addr_r        <= '0;
         issue_cnt_r   <= '0;
         cap_cnt_r     <= '0;
         rd_pend_r     <= 1'b0;
         pack_r        <= '0;
         fill_r        <= '0;
         pack_done_r   <= 1'b0;
         pack_last_r   <= 1'b0;
         out_data_r    <= '0;
         out_valid_r   <= 1'b0;
         out_last_r    <= 1'b0;
         busy_r        <= 1'b0;
         stream_done_r <= 1'b0;
      end else begin
         state_r       <= state_s;
         addr_r        <= addr_s;
         issue_cnt_r   <= issue_cnt_s;
         cap_cnt_r     <= cap_cnt_s;
         rd_pend_r     <= issue_s;
         pack_r        <= pack_s;
         fill_r        <= fill_s;
         pack_done_r   <= pack_done_s;
         pack_last_r   <= pack_last_s;
         out_data_r    <= out_data_s;
         out_valid_r   <= out_valid_s;
         out_last_r    <= out_last_s;
         busy_r        <= busy_s;
         stream_done_r <= stream_done_s;
      end
   end
endmodule

// File: tb/tb_conv_result_streamer.sv
// Directed bench for conv_result_streamer: a full-size instance (7840
// elements) and a small one (10 elements) reading a buffer holding a[3:0].
module tb_conv_result_streamer;
   localparam int BIG_N   = 7840;
   localparam int SMALL_N = 10;
   localparam int N_WORDS = 980;

   logic        clk, resetn;
   logic        start, start_s, acc_done;
   logic [31:0] addr, addr_sm;
   logic [3:0]  rdata, rdata_sm;
   logic        busy, busy_sm, sdone, sdone_sm;

   int n_cmp  = 0;
   int n_fail = 0;

   conv_result_streamer_if #(.DATA_W(4), .PACK(8)) bus ();
   conv_result_streamer_if #(.DATA_W(4), .PACK(8)) bus_s ();

   conv_result_streamer #(.NUM_ELEMS(BIG_N), .DATA_W(4), .PACK(8), .ADDR_W(32)) dut (
      .clk(clk), .resetn(resetn), .start(start), .acc_done(acc_done),
      .acc_read_addr(addr), .acc_read_data(rdata), .m_if(bus),
      .busy(busy), .stream_done(sdone));

   conv_result_streamer #(.NUM_ELEMS(SMALL_N), .DATA_W(4), .PACK(8), .ADDR_W(32)) dut_sm (
      .clk(clk), .resetn(resetn), .start(start_s), .acc_done(acc_done),
      .acc_read_addr(addr_sm), .acc_read_data(rdata_sm), .m_if(bus_s),
      .busy(busy_sm), .stream_done(sdone_sm));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // buffer model with one-cycle read latency: buffer[a] = a[3:0]
   always_ff @(posedge clk) begin
      rdata    <= addr[3:0];
      rdata_sm <= addr_sm[3:0];
   end

   function automatic logic [31:0] exp_word(input int k, input int n);
      logic [31:0] w;
      w = 32'h0;
      for (int j = 0; j < 8; j++) begin
         int a;
         a = k * 8 + j;
         if (a < n) w[j*4 +: 4] = a[3:0];
      end
      return w;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // stream monitor for the full-size instance
   logic        mon_clr;
   int          word_idx, done_cnt, cyc, first_hs, last_hs;
   logic        stall_prev, last_hs_prev;
   logic [31:0] held_data, prev_addr;
   logic        held_last;

   always @(negedge clk) begin
      if (mon_clr || !resetn) begin
         word_idx = 0; done_cnt = 0; cyc = 0; first_hs = 0; last_hs = 0;
         stall_prev = 1'b0; last_hs_prev = 1'b0; prev_addr = addr;
         held_data = 32'h0; held_last = 1'b0;
      end else begin
         cyc++;
         if (stall_prev) begin
            check("stall_valid", {63'h0, bus.m_valid}, 64'h1);
            check("stall_data", {32'h0, bus.m_data}, {32'h0, held_data});
            check("stall_last", {63'h0, bus.m_last}, {63'h0, held_last});
         end
         if (last_hs_prev) begin
            check("done_after_last", {63'h0, sdone}, 64'h1);
            check("busy_drop", {63'h0, busy}, 64'h0);
         end
         if (sdone) done_cnt++;
         if (busy && addr != prev_addr)
            check("addr_step", {32'h0, addr}, {32'h0, prev_addr + 32'd1});
         prev_addr = addr;
         if (bus.m_valid && bus.m_ready) begin
            check("word_data", {32'h0, bus.m_data}, {32'h0, exp_word(word_idx, BIG_N)});
            check("word_last", {63'h0, bus.m_last}, {63'h0, (word_idx == N_WORDS - 1)});
            if (word_idx == 0) first_hs = cyc;
            last_hs = cyc;
            word_idx++;
         end
         stall_prev   = bus.m_valid && !bus.m_ready;
         held_data    = bus.m_data;
         held_last    = bus.m_last;
         last_hs_prev = bus.m_valid && bus.m_ready && bus.m_last;
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic clear_monitor();
      mon_clr = 1'b1;
      @(posedge clk); #1;
      mon_clr = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check("idle_timeout", {63'h0, busy}, 64'h0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_addr"},  {32'h0, addr}, 64'h0);
      check({tag, "_data"},  {32'h0, bus.m_data}, 64'h0);
      check({tag, "_valid"}, {63'h0, bus.m_valid}, 64'h0);
      check({tag, "_last"},  {63'h0, bus.m_last}, 64'h0);
      check({tag, "_busy"},  {63'h0, busy}, 64'h0);
      check({tag, "_done"},  {63'h0, sdone}, 64'h0);
   endtask

   initial begin
      int n, nd;
      logic pulsed;
      resetn = 1'b0; start = 1'b0; start_s = 1'b0; acc_done = 1'b0;
      bus.m_ready = 1'b1; bus_s.m_ready = 1'b1; mon_clr = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      resetn = 1'b1;
      @(posedge clk); #1;
      mon_clr = 1'b0;

      // start while the accelerator is still busy: hold 100 cycles
      pulse_start();
      for (int i = 0; i < 100; i++) begin
         check("wait_busy",  {63'h0, busy}, 64'h1);
         check("wait_addr",  {32'h0, addr}, 64'h0);
         check("wait_valid", {63'h0, bus.m_valid}, 64'h0);
         @(posedge clk); #1;
      end
      acc_done = 1'b1;
      @(posedge clk); #1;
      check("fetch_addr0", {32'h0, addr}, 64'h0);
      @(posedge clk); #1;
      check("fetch_addr1", {32'h0, addr}, 64'h1);
      wait_idle(20000);
      check("full_words", word_idx, N_WORDS);
      check("full_done_pulses", done_cnt, 1);
      check("full_throughput", last_hs - first_hs, (N_WORDS - 1) * 8);
      clear_monitor();

      // random backpressure, acc_done toggling, stray start at word 50
      pulse_start();
      pulsed = 1'b0;
      n = 0;
      while (busy && n < 40000) begin
         bus.m_ready = 1'($urandom_range(0, 1));
         acc_done    = 1'($urandom_range(0, 1));
         start       = (word_idx >= 50) && !pulsed;
         if (start) pulsed = 1'b1;
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0; bus.m_ready = 1'b1; acc_done = 1'b1;
      wait_idle(100);
      check("bp_words", word_idx, N_WORDS);
      check("bp_done_pulses", done_cnt, 1);
      check("bp_stray_start", {31'h0, pulsed}, 64'h1);
      clear_monitor();

      // reset right after the word-100 handshake, then restart
      pulse_start();
      n = 0;
      while (word_idx < 101 && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      check("mid_reached", word_idx, 101);
      resetn = 1'b0;
      #1;
      check_outputs_zero("midreset");
      @(posedge clk); #1;
      resetn = 1'b1;
      clear_monitor();
      pulse_start();
      wait_idle(20000);
      check("restart_words", word_idx, N_WORDS);
      check("restart_done_pulses", done_cnt, 1);

      // 10-element instance: one full word and one zero-filled last word
      start_s = 1'b1;
      @(posedge clk); #1;
      start_s = 1'b0;
      n = 0; nd = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus_s.m_valid && bus_s.m_ready) begin
            check("small_data", {32'h0, bus_s.m_data}, {32'h0, exp_word(n, SMALL_N)});
            check("small_last", {63'h0, bus_s.m_last}, {63'h0, (n == 1)});
            n++;
         end
         if (sdone_sm) nd++;
      end
      check("small_words", n, 2);
      check("small_done_pulses", nd, 1);
      check("small_idle", {63'h0, busy_sm}, 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
